karatsuba_div_32: RTL and testbench
===================================

KARATSUBA_DIV_32 -- requirements
Module: karatsuba_div_32

Interface
REQ-001 SHALL have parameter m, default 16, meaning the divisor and remainder width.
REQ-002 SHALL have parameter n, default 32 (=2*m), meaning the dividend and quotient width.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to begin a division.
REQ-006 SHALL have port A, input, n bits: dividend.
REQ-007 SHALL have port B, input, m bits: divisor.
REQ-008 SHALL have port Q, output, n bits: quotient, registered.
REQ-009 SHALL have port R, output, m bits: remainder, registered.
REQ-010 SHALL have port busy, output, 1 bit: high while a division is in progress.
REQ-011 SHALL have port done, output, 1 bit: single-cycle completion pulse.
REQ-012 SHALL have port div0, output, 1 bit: result flag for a zero divisor, valid with done.

Function
REQ-013 SHALL implement states IDLE, RUN and DONE.
REQ-014 SHALL accept start only in IDLE or DONE; when start is high at edge E0, A and B are latched, busy rises and the state enters RUN.
REQ-015 SHALL ignore start while busy=1; the latched operands are unaffected.
REQ-016 SHALL perform restoring division in RUN, one quotient bit per edge, MSB first, using an (m+1)-bit partial remainder: shift left, append the next dividend bit, subtract the divisor when the partial remainder is >= the divisor, and set the quotient bit.
REQ-017 SHALL complete in exactly n iterations on edges E1..En; at En, Q and R are written, busy=0, done=1, and the state enters DONE.
REQ-018 SHALL hold done high for exactly one cycle, then return to 0 on the next edge (DONE->IDLE, unless start re-arms).
REQ-019 SHALL hold Q, R and div0 stable from completion until the edge that accepts the next start.
REQ-020 SHALL produce results satisfying Q*B + R == A and R < B for every B != 0.
REQ-021 SHALL, for B == 0, produce Q = all ones, R = A[m-1:0], div0=1, with the same latency as a normal division (unless overridden by REQ-025).
REQ-022 SHALL allow start in DONE (the same cycle done is high) to begin a new division immediately; the new E0 is that edge.

Reset
REQ-023 SHALL, when rst is high, immediately force state=IDLE, Q=0, R=0, busy=0, done=0, div0=0, regardless of clock.
REQ-024 SHALL, on reset during RUN, abandon the division without asserting done; start is honoured only on the first rising edge after rst falls.

Configuration
REQ-025 SHALL, when macro KDIV_FAST_EXIT_EN is defined, complete in one cycle when B == 0 or A < {n-m zeros, B}: at E1, done=1, busy=0, Q=0/R=A[m-1:0] (A<B) or per REQ-021 (B==0).
REQ-026 SHALL, when KDIV_FAST_EXIT_EN is undefined, take exactly n iterations for every operand pair; results are identical in both builds.

Verification
REQ-027 SHALL cover: A=100, B=7, start at E0 -> done at E32, Q=14, R=2, div0=0, busy high E0..E31.
REQ-028 SHALL cover: A=0xFFFFFFFF, B=0xFFFF -> Q=0x00010001, R=0x0000; then A=0x12345678, B=0x0001 -> Q=0x12345678, R=0.
REQ-029 SHALL cover: A=1234, B=0 -> Q=0xFFFFFFFF, R=0x04D2, div0=1; done at E32 without the macro, at E1 with it.
REQ-030 SHALL cover: A=5, B=9 -> Q=0, R=5; done at E32 without the macro, at E1 with it.
REQ-031 SHALL cover: start re-pulsed with A=1, B=1 at E10 of the A=100/B=7 operation -> ignored; result is still Q=14, R=2 at E32.
REQ-032 SHALL cover: rst asserted at E15 of a division -> all outputs 0 asynchronously and no done pulse; a new start after rst falls yields a correct result.

Source files
------------

// File: rtl/karatsuba_div_32.sv
`default_nettype none
// ============================================================================
// Module      : karatsuba_div_32
// Description : Sequential restoring divider, n-bit dividend by m-bit divisor,
//               one quotient bit per clock. Define KDIV_FAST_EXIT_EN to
//               finish in one cycle when B == 0 or A < B.
// Revision    : 1.0 - initial release
// ============================================================================
module karatsuba_div_32 #(
    parameter int m = 16,
    parameter int n = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [n-1:0] A,
    input  logic [m-1:0] B,
    output logic [n-1:0] Q,
    output logic [m-1:0] R,
    output logic         busy,
    output logic         done,
    output logic         div0
);

    localparam int                 c_CNT_W = (n > 1) ? $clog2(n) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(n - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;

    // r_dvd holds the dividend and is progressively replaced by quotient bits
    logic [n-1:0]         r_dvd;
    logic [m-1:0]         r_dvs;
    logic [m:0]           r_rem;
    logic [c_CNT_W-1:0]   r_cnt;

    logic [m:0]           w_shift;
    logic [m:0]           w_diff;
    logic                 w_ge;
    logic [m:0]           w_rem_next;
    logic [n-1:0]         w_quo_next;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_fast;
    logic                 w_finish;
    logic                 w_dvs_zero;
    logic                 w_unused;

    assign w_shift    = {r_rem[m-1:0], r_dvd[n-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_diff     = w_shift - {1'b0, r_dvs};
    assign w_rem_next = w_ge ? w_diff : w_shift;
    assign w_quo_next = {r_dvd[n-2:0], w_ge};
    assign w_dvs_zero = (r_dvs == '0);

    // The top remainder bit is always clear after a restoring step
    assign w_unused   = r_rem[m];

    assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_last   = (r_state == RUN) && (r_cnt == c_LAST);

`ifdef KDIV_FAST_EXIT_EN
    assign w_fast = (r_state == RUN) && (r_cnt == '0) &&
                    (w_dvs_zero || (r_dvd < n'(r_dvs)));
`else
    assign w_fast = 1'b0;
`endif

    assign w_finish = w_last || w_fast;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (start) w_next_state = RUN;
            RUN:     if (w_finish) w_next_state = DONE;
            DONE:    w_next_state = start ? RUN : IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dvd <= '0;
            r_dvs <= '0;
            r_rem <= '0;
            r_cnt <= '0;
            Q     <= '0;
            R     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            div0  <= 1'b0;
        end else if (w_accept) begin
            r_dvd <= A;
            r_dvs <= B;
            r_rem <= '0;
            r_cnt <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else if (r_state == RUN) begin
            r_dvd <= w_quo_next;
            r_rem <= w_rem_next;
            r_cnt <= r_cnt + c_CNT_W'(1);
            if (w_finish) begin
                busy <= 1'b0;
                done <= 1'b1;
                div0 <= w_dvs_zero;
                if (w_fast) begin
                    // Early exit: quotient is all ones for B == 0, else zero
                    Q <= w_dvs_zero ? '1 : '0;
                    R <= r_dvd[m-1:0];
                end else begin
                    Q <= w_quo_next;
                    R <= w_rem_next[m-1:0];
                end
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_karatsuba_div_32.sv
`default_nettype none
// Self-checking bench for karatsuba_div_32: directed divisions with a
// queue of expected results compared at each done pulse.
module tb_karatsuba_div_32;

`ifdef KDIV_FAST_EXIT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] A;
    logic [15:0] B;
    logic [31:0] Q;
    logic [15:0] R;
    logic        busy;
    logic        done;
    logic        div0;

    typedef struct {
        logic [31:0] q;
        logic [15:0] r;
        logic        d0;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    karatsuba_div_32 #(.m(16), .n(32)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .div0  (div0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] a, input logic [15:0] b);
        exp_t e;
        if (b == 16'd0) begin
            e.q  = 32'hFFFF_FFFF;
            e.r  = a[15:0];
            e.d0 = 1'b1;
        end else begin
            e.q  = a / {16'd0, b};
            e.r  = 16'(a % {16'd0, b});
            e.d0 = 1'b0;
        end
        e.lat = (FAST && ((b == 16'd0) || (a < {16'd0, b}))) ? 1 : 32;
        return e;
    endfunction

    // Starts a division at the next edge (E0), waits for done and checks it.
    // repulse_at > 0 drives a competing start with A=1,B=1 at that edge.
    task automatic run_div(input logic [31:0] a, input logic [15:0] b, input int repulse_at);
        exp_t e;
        int   k;
        sb.push_back(model(a, b));
        A     = a;
        B     = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        A     = $urandom;
        B     = 16'($urandom);
        k     = 0;
        if (!done) chk("busy_e0", {63'd0, busy}, 64'd1);
        while (!done && k < 40) begin
            if (repulse_at > 0 && k + 1 == repulse_at) begin
                start = 1'b1;
                A     = 32'd1;
                B     = 16'd1;
            end
            tick();
            k++;
            start = 1'b0;
            if (!done) chk("busy_run", {63'd0, busy}, 64'd1);
        end
        e = sb.pop_front();
        chk("latency", 64'(k), 64'(e.lat));
        chk("done", {63'd0, done}, 64'd1);
        chk("busy_end", {63'd0, busy}, 64'd0);
        chk("Q", {32'd0, Q}, {32'd0, e.q});
        chk("R", {48'd0, R}, {48'd0, e.r});
        chk("div0", {63'd0, div0}, {63'd0, e.d0});
    endtask

    // One idle cycle after completion: done drops, results stay put
    task automatic check_hold(input logic [31:0] a, input logic [15:0] b);
        exp_t e;
        e = model(a, b);
        tick();
        chk("done_drop", {63'd0, done}, 64'd0);
        chk("Q_hold", {32'd0, Q}, {32'd0, e.q});
        chk("R_hold", {48'd0, R}, {48'd0, e.r});
        chk("div0_hold", {63'd0, div0}, {63'd0, e.d0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        #12;
        chk("rst_Q", {32'd0, Q}, 64'd0);
        chk("rst_R", {48'd0, R}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_div0", {63'd0, div0}, 64'd0);
        tick();
        rst = 1'b0;
        tick();

        // Basic case with an ignored re-start in the middle
        run_div(32'd100, 16'd7, 10);
        check_hold(32'd100, 16'd7);

        // Max operands, then back-to-back start while done is high
        run_div(32'hFFFF_FFFF, 16'hFFFF, 0);
        run_div(32'h1234_5678, 16'h0001, 0);
        check_hold(32'h1234_5678, 16'h0001);

        // Divide by zero
        run_div(32'd1234, 16'd0, 0);
        check_hold(32'd1234, 16'd0);

        // Dividend smaller than divisor
        run_div(32'd5, 16'd9, 0);
        check_hold(32'd5, 16'd9);

        // Reset in the middle of a division
        A     = 32'hDEAD_BEEF;
        B     = 16'h1234;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 0; i < 14; i++) tick();
        #2;
        rst = 1'b1;
        #1;
        chk("arst_Q", {32'd0, Q}, 64'd0);
        chk("arst_R", {48'd0, R}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        chk("arst_div0", {63'd0, div0}, 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_done", {63'd0, done}, 64'd0);
        end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            chk("post_rst_no_done", {63'd0, done}, 64'd0);
        end
        run_div(32'hDEAD_BEEF, 16'h1234, 0);
        check_hold(32'hDEAD_BEEF, 16'h1234);

        // A few random operand pairs, including small divisors
        for (int i = 0; i < 4; i++) begin
            logic [31:0] ra;
            logic [15:0] rb;
            ra = $urandom;
            rb = (i == 3) ? 16'hFFF0 : 16'($urandom_range(1, 65535));
            if (i == 3) ra = 32'h0000_1234;
            run_div(ra, rb, 0);
        end
        check_hold(32'h0000_1234, 16'hFFF0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
